// File: rtl/ad5328_multi_ctrl.sv
// ad5328_multi_ctrl: multi-channel controller for the AD5308/AD5318/AD5328 DAC family.
// Keeps a shadow value and dirty flag per channel, streams changed channels
// lowest index first as 16-bit SPI frames, and drives LDAC on request.
// The INIT_WORD control frame is sent once after every reset.
// Optional build macro: AD5328_AUTO_LDAC_EN makes every burst of writes end
// with one automatic LDAC pulse.
module ad5328_multi_ctrl #(
  parameter int unsigned NUM_CH    = 8,
  parameter int unsigned DATA_W    = 12,
  parameter int unsigned CLK_DIV   = 4,
  parameter logic [15:0] INIT_WORD = 16'h8000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_en,
  input  logic [2:0]        wr_ch,
  input  logic [DATA_W-1:0] wr_data,
  output logic              wr_ready,
  input  logic              update,
  output logic              busy,
  output logic              init_done,
  output logic              ldac_n,
  output logic              sync_n,
  output logic              sclk,
  output logic              dout
);

  localparam int unsigned CNT_W = $clog2(2 * CLK_DIV);
  localparam logic [CNT_W-1:0] DIV_LAST  = CNT_W'(CLK_DIV - 1);
  // GAP is one cycle short of 2*CLK_DIV: the following IDLE cycle completes the
  // 2*CLK_DIV high time ahead of LDAC and gives a 34*CLK_DIV+1 frame period.
  localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(2 * CLK_DIV - 2);
  localparam logic [CNT_W-1:0] LDAC_LAST = CNT_W'(2 * CLK_DIV - 1);

  typedef enum logic [2:0] {
    S_INIT_LOAD,
    S_LOAD,
    S_SHIFT,
    S_GAP,
    S_IDLE,
    S_LDAC
  } state_t;

  state_t            state;
  state_t            state_nx;
  logic [11:0]       shadow [NUM_CH];
  logic [NUM_CH-1:0] dirty;
  logic [NUM_CH-1:0] dirty_d;
  logic [NUM_CH-1:0] wr_mask;
  logic [NUM_CH-1:0] sel_mask;
  logic              ldac_req;
  logic              ldac_req_d;
  logic              auto_req;
  logic [15:0]       shreg;
  logic [CNT_W-1:0]  cnt;
  logic [4:0]        hcnt;
  logic [2:0]        sel_ch;
  logic [11:0]       sel_val;
  logic [11:0]       wr_val;
  logic              wr_acc;
  logic              any_dirty;
  logic              found;
  logic              div_end;
  logic              shift_end;
  logic              gap_end;
  logic              ldac_end;

  assign wr_ready = init_done;
  assign dout     = shreg[15];

  // Write acceptance, left-justification and lowest-index dirty channel select
  always_comb begin
    wr_acc    = wr_en && init_done && ({29'd0, wr_ch} < NUM_CH);
    wr_val    = 12'(wr_data) << (12 - DATA_W);
    any_dirty = |dirty;
    found     = 1'b0;
    sel_ch    = '0;
    sel_val   = '0;
    wr_mask   = '0;
    sel_mask  = '0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      wr_mask[i] = wr_acc && (wr_ch == 3'(i));
      if (dirty[i] && !found) begin
        found       = 1'b1;
        sel_ch      = 3'(i);
        sel_val     = shadow[i];
        sel_mask[i] = 1'b1;
      end
    end
  end

  // Timing terminal counts and next dirty/ldac_req values
  always_comb begin
    div_end   = (cnt == DIV_LAST);
    shift_end = (state == S_SHIFT) && div_end && (hcnt == 5'd31);
    gap_end   = (state == S_GAP) && (cnt == GAP_LAST);
    ldac_end  = (state == S_LDAC) && (cnt == LDAC_LAST);
`ifdef AD5328_AUTO_LDAC_EN
    auto_req  = gap_end && init_done && !any_dirty && !wr_acc;
`else
    auto_req  = 1'b0;
`endif
    dirty_d = dirty;
    if (state == S_LOAD) dirty_d = dirty_d & ~sel_mask;
    dirty_d = dirty_d | wr_mask;
    ldac_req_d = ldac_req;
    if (state == S_IDLE && !any_dirty && ldac_req) ldac_req_d = 1'b0;
    if (update || auto_req) ldac_req_d = 1'b1;
  end

  // Next-state logic; dirty channels win over a pending LDAC
  always_comb begin
    state_nx = state;
    unique case (state)
      S_INIT_LOAD: state_nx = S_SHIFT;
      S_LOAD:      state_nx = S_SHIFT;
      S_SHIFT:     if (shift_end) state_nx = S_GAP;
      S_GAP:       if (gap_end) state_nx = S_IDLE;
      S_IDLE: begin
        if (any_dirty)     state_nx = S_LOAD;
        else if (ldac_req) state_nx = S_LDAC;
      end
      S_LDAC:      if (ldac_end) state_nx = S_IDLE;
      default:     state_nx = S_INIT_LOAD;
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) state <= S_INIT_LOAD;
    else        state <= state_nx;
  end

  // Shadow array, request flags, shift datapath and registered pin outputs
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < NUM_CH; i++) shadow[i] <= '0;
      dirty     <= '0;
      ldac_req  <= 1'b0;
      shreg     <= '0;
      cnt       <= '0;
      hcnt      <= '0;
      sclk      <= 1'b1;
      sync_n    <= 1'b1;
      ldac_n    <= 1'b1;
      busy      <= 1'b0;
      init_done <= 1'b0;
    end else begin
      for (int unsigned i = 0; i < NUM_CH; i++) begin
        if (wr_mask[i]) shadow[i] <= wr_val;
      end
      dirty    <= dirty_d;
      ldac_req <= ldac_req_d;
      sync_n   <= (state_nx != S_SHIFT);
      ldac_n   <= (state_nx != S_LDAC);
      busy     <= (state_nx != S_IDLE) || (|dirty_d) || ldac_req_d;
      if (gap_end) init_done <= 1'b1;
      unique case (state)
        S_INIT_LOAD: begin
          shreg <= INIT_WORD;
          cnt   <= '0;
          hcnt  <= '0;
        end
        S_LOAD: begin
          shreg <= {1'b0, sel_ch, sel_val};
          cnt   <= '0;
          hcnt  <= '0;
        end
        S_SHIFT: begin
          if (div_end) begin
            cnt  <= '0;
            sclk <= ~sclk;
            hcnt <= hcnt + 5'd1;
            // rising edge: present the next bit
            if (!sclk) shreg <= {shreg[14:0], 1'b0};
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_GAP:   cnt <= gap_end ? '0 : cnt + 1'b1;
        S_LDAC:  cnt <= ldac_end ? '0 : cnt + 1'b1;
        default: cnt <= '0;
      endcase
    end
  end

endmodule

// File: tb/tb_ad5328_multi_ctrl.sv
// tb_ad5328_multi_ctrl: scoreboard bench for ad5328_multi_ctrl.
// Main instance: 8 channels, 12-bit, CLK_DIV=4. Second instance: 4 channels,
// 8-bit, CLK_DIV=2 for channel-range and left-justification checks.
module tb_ad5328_multi_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, wr_en, update;
  logic [2:0]  wr_ch;
  logic [11:0] wr_data;
  logic        wr_ready, busy, init_done, ldac_n, sync_n, sclk, dout;

  logic        wr_en2, update2;
  logic [2:0]  wr_ch2;
  logic [7:0]  wr_data2;
  logic        wr_ready2, busy2, init_done2, ldac_n2, sync_n2, sclk2, dout2;

  ad5328_multi_ctrl #(.NUM_CH(8), .DATA_W(12), .CLK_DIV(4), .INIT_WORD(16'h8000)) dut (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_ch(wr_ch), .wr_data(wr_data),
    .wr_ready(wr_ready), .update(update), .busy(busy), .init_done(init_done),
    .ldac_n(ldac_n), .sync_n(sync_n), .sclk(sclk), .dout(dout));

  ad5328_multi_ctrl #(.NUM_CH(4), .DATA_W(8), .CLK_DIV(2), .INIT_WORD(16'h8000)) dut2 (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en2), .wr_ch(wr_ch2), .wr_data(wr_data2),
    .wr_ready(wr_ready2), .update(update2), .busy(busy2), .init_done(init_done2),
    .ldac_n(ldac_n2), .sync_n(sync_n2), .sclk(sclk2), .dout(dout2));

  int n_cmp = 0;
  int n_bad = 0;
  logic [15:0] exp_q[$];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // LDAC pulse bookkeeping for the main instance
  int pulses = 0, cur_len = 0, last_len = 0, ldac_fall = 0, overlap = 0;
  always @(negedge clk) begin
    if (ldac_n === 1'b0 && sync_n === 1'b0) overlap++;
    if (ldac_n === 1'b0) begin
      if (cur_len == 0) ldac_fall = cyc;
      cur_len++;
    end else if (cur_len > 0) begin
      last_len = cur_len;
      pulses++;
      cur_len = 0;
    end
  end

  logic mon_sel = 1'b0;
  logic m_sync, m_sclk, m_dout;
  assign m_sync = mon_sel ? sync_n2 : sync_n;
  assign m_sclk = mon_sel ? sclk2 : sclk;
  assign m_dout = mon_sel ? dout2 : dout;

  // Capture one frame: word sampled on sclk falls, bit count, sync_n low time
  task automatic get_frame(input int maxw, output logic [15:0] w, output logic b15,
                           output int nf, output int len, output int t0, output bit ok);
    int t;
    logic ps;
    w = '0; b15 = 1'b0; nf = 0; len = 0; t0 = 0; ok = 1'b0; t = 0;
    while (m_sync !== 1'b0 && t < maxw) begin
      @(posedge clk); #1; t++;
    end
    if (m_sync !== 1'b0) return;
    t0 = cyc;
    b15 = m_dout;
    ps = m_sclk;
    while (m_sync === 1'b0 && len < 1000) begin
      len++;
      @(posedge clk); #1;
      if (ps === 1'b1 && m_sclk === 1'b0) begin
        w = {w[14:0], m_dout};
        nf++;
      end
      ps = m_sclk;
    end
    ok = (m_sync === 1'b1);
  endtask

  task automatic step(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic test_reset();
    logic [15:0] w, e;
    logic b15;
    int nf, len, t0, n, p0;
    bit ok;
    rst_n = 1'b0;
    repeat (4) begin
      step(1);
      n_cmp++;
      if ({sync_n, sclk, dout, ldac_n, busy, init_done, wr_ready} !== 7'b1101000) begin
        n_bad++;
        $display("FAIL reset_hold: outputs %b, required 1101000",
                 {sync_n, sclk, dout, ldac_n, busy, init_done, wr_ready});
      end
    end
    p0 = pulses;
    exp_q.push_back(16'h8000);
    rst_n = 1'b1;
    get_frame(50, w, b15, nf, len, t0, ok);
    e = exp_q.pop_front();
    n_cmp++;
    if ({ok, b15, w} !== {1'b1, e[15], e}) begin
      n_bad++;
      $display("FAIL init_frame: ok=%0d bit15=%0d word=%h, required 1 %0d %h", ok, b15, w, e[15], e);
    end
    n_cmp++;
    if (nf != 16 || len != 128) begin
      n_bad++;
      $display("FAIL init_shape: falls=%0d low=%0d, required 16 128", nf, len);
    end
    n = 0;
    while (init_done !== 1'b1 && n < 100) begin step(1); n++; end
    n_cmp++;
    if (n != 7 || wr_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL init_done_time: %0d cycles wr_ready=%b, required 7 cycles wr_ready=1", n, wr_ready);
    end
    step(30);
    n_cmp++;
    if (pulses != p0 || busy !== 1'b0) begin
      n_bad++;
      $display("FAIL init_no_ldac: pulses=%0d busy=%b, required 0 0", pulses - p0, busy);
    end
  endtask

  task automatic test_single_write();
    logic [15:0] w, e;
    logic b15;
    int nf, len, t0, n, p0, k;
    bit ok;
    p0 = pulses;
    exp_q.push_back(16'h5ABC);
    k = cyc;
    wr_en = 1'b1; wr_ch = 3'd5; wr_data = 12'hABC;
    step(1);
    wr_en = 1'b0; update = 1'b1;
    step(1);
    update = 1'b0;
    get_frame(50, w, b15, nf, len, t0, ok);
    e = exp_q.pop_front();
    n_cmp++;
    if ({ok, b15, w} !== {1'b1, e[15], e}) begin
      n_bad++;
      $display("FAIL ch5_frame: ok=%0d bit15=%0d word=%h, required 1 %0d %h", ok, b15, w, e[15], e);
    end
    // write sampled at edge k+1, LOAD entered at k+2, sync_n low from k+3
    n_cmp++;
    if (t0 != k + 3 || nf != 16 || len != 128) begin
      n_bad++;
      $display("FAIL ch5_timing: start=%0d falls=%0d low=%0d, required %0d 16 128", t0, nf, len, k + 3);
    end
    n = 0;
    while ((pulses == p0 || ldac_n !== 1'b1) && n < 200) begin step(1); n++; end
    n_cmp++;
    if (pulses - p0 != 1 || last_len != 8) begin
      n_bad++;
      $display("FAIL ldac_pulse: count=%0d len=%0d, required 1 8", pulses - p0, last_len);
    end
    n_cmp++;
    if (ldac_fall - (t0 + len) != 8) begin
      n_bad++;
      $display("FAIL ldac_gap: %0d cycles after sync_n rise, required 8", ldac_fall - (t0 + len));
    end
  endtask

  task automatic test_ordering();
    logic [15:0] w, e;
    logic b15;
    int nf, len, t0, prev_t0, n;
    bit ok;
    exp_q.push_back(16'h0002);
    exp_q.push_back(16'h3003);
    exp_q.push_back(16'h7001);
    wr_en = 1'b1; wr_ch = 3'd7; wr_data = 12'd1;
    step(1);
    wr_ch = 3'd0; wr_data = 12'd2;
    step(1);
    wr_ch = 3'd3; wr_data = 12'd3;
    step(1);
    wr_en = 1'b0;
    prev_t0 = 0;
    for (int i = 0; i < 3; i++) begin
      get_frame(300, w, b15, nf, len, t0, ok);
      e = exp_q.pop_front();
      n_cmp++;
      if ({ok, w} !== {1'b1, e}) begin
        n_bad++;
        $display("FAIL order_frame%0d: ok=%0d word=%h, required 1 %h", i, ok, w, e);
      end
      if (i > 0) begin
        n_cmp++;
        if (t0 - prev_t0 != 137) begin
          n_bad++;
          $display("FAIL frame_period%0d: %0d cycles, required 137", i, t0 - prev_t0);
        end
      end
      prev_t0 = t0;
    end
    n = 0;
    while (busy === 1'b1 && n < 100) begin step(1); n++; end
    n_cmp++;
    if (n != 7) begin
      n_bad++;
      $display("FAIL busy_tail: busy for %0d cycles after last frame, required 7", n);
    end
  endtask

  task automatic test_load_collision();
    logic [15:0] w, e;
    logic b15;
    int nf, len, t0;
    bit ok;
    exp_q.push_back(16'h2032);
    exp_q.push_back(16'h2064);
    wr_en = 1'b1; wr_ch = 3'd2; wr_data = 12'd50;
    step(1);
    wr_en = 1'b0;
    step(1);
    wr_en = 1'b1; wr_data = 12'd100;
    step(1);
    wr_en = 1'b0;
    for (int i = 0; i < 2; i++) begin
      get_frame(300, w, b15, nf, len, t0, ok);
      e = exp_q.pop_front();
      n_cmp++;
      if ({ok, w} !== {1'b1, e}) begin
        n_bad++;
        $display("FAIL collide_frame%0d: ok=%0d word=%h, required 1 %h", i, ok, w, e);
      end
    end
    step(20);
  endtask

  task automatic test_auto_ldac();
    logic [15:0] w, e;
    logic b15;
    int nf, len, t0, p0, want;
    bit ok;
`ifdef AD5328_AUTO_LDAC_EN
    want = 1;
`else
    want = 0;
`endif
    p0 = pulses;
    exp_q.push_back(16'h47FF);
    exp_q.push_back(16'h6123);
    wr_en = 1'b1; wr_ch = 3'd4; wr_data = 12'h7FF;
    step(1);
    wr_ch = 3'd6; wr_data = 12'h123;
    step(1);
    wr_en = 1'b0;
    for (int i = 0; i < 2; i++) begin
      get_frame(300, w, b15, nf, len, t0, ok);
      e = exp_q.pop_front();
      n_cmp++;
      if ({ok, w} !== {1'b1, e}) begin
        n_bad++;
        $display("FAIL burst_frame%0d: ok=%0d word=%h, required 1 %h", i, ok, w, e);
      end
    end
    step(120);
    n_cmp++;
    if (pulses - p0 != want) begin
      n_bad++;
      $display("FAIL burst_ldac: %0d pulses without update, required %0d", pulses - p0, want);
    end
  endtask

  task automatic test_reset_midframe();
    logic [15:0] w, e;
    logic b15;
    int nf, len, t0, n, p0, falls;
    bit ok;
    logic ps;
    p0 = pulses;
    wr_en = 1'b1; wr_ch = 3'd1; wr_data = 12'h123;
    step(1);
    wr_en = 1'b0; update = 1'b1;
    step(1);
    update = 1'b0;
    n = 0;
    while (sync_n !== 1'b0 && n < 50) begin step(1); n++; end
    falls = 0; ps = sclk; n = 0;
    while (falls < 8 && n < 200) begin
      step(1); n++;
      if (ps === 1'b1 && sclk === 1'b0) falls++;
      ps = sclk;
    end
    n_cmp++;
    if (falls != 8 || sync_n !== 1'b0) begin
      n_bad++;
      $display("FAIL midframe_reach: falls=%0d sync_n=%b, required 8 0", falls, sync_n);
    end
    rst_n = 1'b0;
    step(1);
    n_cmp++;
    if ({sync_n, sclk, dout, ldac_n, init_done} !== 5'b11010) begin
      n_bad++;
      $display("FAIL midframe_reset: outputs %b, required 11010", {sync_n, sclk, dout, ldac_n, init_done});
    end
    step(1);
    exp_q.push_back(16'h8000);
    rst_n = 1'b1;
    get_frame(50, w, b15, nf, len, t0, ok);
    e = exp_q.pop_front();
    n_cmp++;
    if ({ok, w} !== {1'b1, e}) begin
      n_bad++;
      $display("FAIL reinit_frame: ok=%0d word=%h, required 1 %h", ok, w, e);
    end
    n = 0;
    while (init_done !== 1'b1 && n < 100) begin step(1); n++; end
    get_frame(300, w, b15, nf, len, t0, ok);
    n_cmp++;
    if (ok || init_done !== 1'b1 || pulses != p0 || busy !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_clears: frame=%0d init_done=%b pulses=%0d busy=%b, required 0 1 0 0",
               ok, init_done, pulses - p0, busy);
    end
  endtask

  task automatic test_bad_channel();
    logic [15:0] w, e;
    logic b15;
    int nf, len, t0, n, hits;
    bit ok;
    n = 0;
    while (init_done2 !== 1'b1 && n < 200) begin step(1); n++; end
    step(5);
    wr_en2 = 1'b1; wr_ch2 = 3'd6; wr_data2 = 8'h55;
    step(1);
    wr_en2 = 1'b0;
    hits = 0;
    repeat (60) begin
      step(1);
      if (busy2 !== 1'b0 || sync_n2 !== 1'b1) hits++;
    end
    n_cmp++;
    if (hits != 0 || init_done2 !== 1'b1) begin
      n_bad++;
      $display("FAIL bad_channel: %0d active cycles init_done=%b, required 0 1", hits, init_done2);
    end
    exp_q.push_back(16'h3A50);
    mon_sel = 1'b1;
    wr_en2 = 1'b1; wr_ch2 = 3'd3; wr_data2 = 8'hA5;
    step(1);
    wr_en2 = 1'b0;
    get_frame(50, w, b15, nf, len, t0, ok);
    mon_sel = 1'b0;
    e = exp_q.pop_front();
    n_cmp++;
    if ({ok, w} !== {1'b1, e} || nf != 16 || len != 64) begin
      n_bad++;
      $display("FAIL narrow_frame: ok=%0d word=%h falls=%0d low=%0d, required 1 %h 16 64",
               ok, w, nf, len, e);
    end
  endtask

  task automatic test_ldac_overlap();
    n_cmp++;
    if (overlap != 0 || exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL ldac_overlap: overlap=%0d leftover=%0d, required 0 0", overlap, exp_q.size());
    end
  endtask

  initial begin
    rst_n = 1'b0; wr_en = 1'b0; update = 1'b0; wr_ch = '0; wr_data = '0;
    wr_en2 = 1'b0; update2 = 1'b0; wr_ch2 = '0; wr_data2 = '0;
    step(1);
    test_reset();
    test_single_write();
    test_ordering();
    test_load_collision();
    test_auto_ldac();
    test_reset_midframe();
    test_bad_channel();
    test_ldac_overlap();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
